// File: rtl/pipeline_control_pkg.sv
// Shared encodings, stage records and the forwarding helper for the
// three-stage RV32I pipeline controller.
package pipeline_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] PC_HOLD   = 2'd0;
  localparam logic [1:0] PC_PLUS4  = 2'd1;
  localparam logic [1:0] PC_TARGET = 2'd2;
  localparam logic [1:0] PC_RESET  = 2'd3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_X  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  localparam logic [1:0] WB_PC4  = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd1;
  localparam logic [1:0] WB_DMEM = 2'd2;
  localparam logic [1:0] WB_UART = 2'd3;

  localparam logic [3:0] UART_REGION = 4'h8;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
    CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP
  } inst_class_e;

  typedef enum logic {ST_RESET_SEQ, ST_RUN} ctrl_state_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        wr;
    logic        is_load;
    logic        is_store;
    inst_class_e cls;
  } x_stage_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        wr;
    inst_class_e cls;
  } m_stage_t;

  // used already folds in "source register is nonzero".
  function automatic logic [1:0] fwd_src(input logic used, input logic [4:0] src,
                                         input x_stage_t x, input m_stage_t m);
    if (!used) return FWD_RF;
    if (x.valid && x.wr && !x.is_load && (x.rd == src)) return FWD_X;
    if (m.valid && m.wr && (m.rd == src)) return FWD_M;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// Datapath-facing signal bundle of the pipeline controller. There is no
// handshake: all signals are level-valid every cycle, inputs sampled and
// outputs produced combinationally within the same clock period.
interface pipeline_control_if
  import pipeline_ctrl_pkg::*;
();
  logic [31:0] inst;
  logic        branch_taken;
  logic [3:0]  addr_M_hi;
  logic [1:0]  PC_sel;
  logic [1:0]  fwd_sel_a;
  logic [1:0]  fwd_sel_b;
  logic        stall;
  logic        flush;
  logic        dmem_we;
  logic        RegWr;
  logic [1:0]  MemToReg;
  logic        illegal_inst;
  ctrl_state_e state;

  modport master (
    input  inst, branch_taken, addr_M_hi,
    output PC_sel, fwd_sel_a, fwd_sel_b, stall, flush, dmem_we,
           RegWr, MemToReg, illegal_inst, state
  );

  modport slave (
    output inst, branch_taken, addr_M_hi,
    input  PC_sel, fwd_sel_a, fwd_sel_b, stall, flush, dmem_we,
           RegWr, MemToReg, illegal_inst, state
  );
endinterface

// File: rtl/pipeline_control_decode.sv
// Combinational opcode classifier for the D-stage instruction: class,
// register-write flag, source usage and illegal-opcode detection.
module inst_class_decode
  import pipeline_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output inst_class_e cls,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        wr,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        illegal
);
  logic unused_bits;
  assign unused_bits = ^{inst[31:25], inst[14:12]};

  assign rd  = inst[11:7];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];

  always_comb begin
    cls     = CLS_NONE;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_OPIMM:  cls = CLS_OPIMM;
      OPC_OP:     cls = CLS_OP;
      default:    illegal = 1'b1;
    endcase
  end

  // x0 as a destination or source never creates a dependency.
  assign wr       = !(cls inside {CLS_NONE, CLS_BRANCH, CLS_STORE}) && (rd != 5'd0);
  assign uses_rs1 = (cls inside {CLS_JALR, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP})
                    && (rs1 != 5'd0);
  assign uses_rs2 = (cls inside {CLS_BRANCH, CLS_STORE, CLS_OP}) && (rs2 != 5'd0);
endmodule

// File: rtl/pipeline_control.sv
// Sequencing controller for the three-stage RV32I datapath: tracks X/M
// stage records and drives PC, forwarding, stall/flush and writeback selects.
module pipeline_control
  import pipeline_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 2
) (
  input logic                Clock,
  input logic                Reset_n,
  pipeline_control_if.master bus
);
  localparam int CW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

  inst_class_e d_cls;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic        d_wr, d_use1, d_use2, d_ill;

  inst_class_decode u_decode (
    .inst     (bus.inst),
    .cls      (d_cls),
    .rd       (d_rd),
    .rs1      (d_rs1),
    .rs2      (d_rs2),
    .wr       (d_wr),
    .uses_rs1 (d_use1),
    .uses_rs2 (d_use2),
    .illegal  (d_ill)
  );

  ctrl_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  x_stage_t      x_q, x_d;
  m_stage_t      m_q;
  logic          illegal_q;

  logic          in_seq, branch_redirect, load_use, d_jump, kill;
  logic [1:0]    pc_sel, fwd_a, fwd_b, mem_to_reg;
  logic          stall, flush;

  // Reset sequencing FSM: counts RESET_CYCLES edges after release.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_RESET_SEQ;
      cnt_q   <= CW'(RESET_CYCLES);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET_SEQ: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_RUN;
      end
      ST_RUN:  cnt_d = cnt_q;
      default: state_d = ST_RESET_SEQ;
    endcase
  end

  assign in_seq          = (state_q == ST_RESET_SEQ);
  assign branch_redirect = x_q.valid && (x_q.cls == CLS_BRANCH) && bus.branch_taken;
  assign load_use        = x_q.valid && x_q.is_load &&
                           ((d_use1 && (x_q.rd == d_rs1)) || (d_use2 && (x_q.rd == d_rs2)));
  assign d_jump          = (d_cls == CLS_JAL) || (d_cls == CLS_JALR);

  always_comb begin
    pc_sel = PC_PLUS4;
    stall  = 1'b0;
    flush  = 1'b0;
    fwd_a  = fwd_src(d_use1, d_rs1, x_q, m_q);
    fwd_b  = fwd_src(d_use2, d_rs2, x_q, m_q);
    if (in_seq) begin
      pc_sel = PC_RESET;
      flush  = 1'b1;
      fwd_a  = FWD_RF;
      fwd_b  = FWD_RF;
    end else if (branch_redirect) begin
      pc_sel = PC_TARGET;
      flush  = 1'b1;
    end else if (load_use) begin
      pc_sel = PC_HOLD;
      stall  = 1'b1;
    end else if (d_jump) begin
      pc_sel = PC_TARGET;
    end
  end

  assign kill = stall || flush;

  // Illegal opcodes enter X as a bubble; only the sticky flag records them.
  always_comb begin
    x_d = '0;
    if (!kill && !d_ill) begin
      x_d.valid    = 1'b1;
      x_d.rd       = d_rd;
      x_d.wr       = d_wr;
      x_d.is_load  = (d_cls == CLS_LOAD);
      x_d.is_store = (d_cls == CLS_STORE);
      x_d.cls      = d_cls;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q       <= '0;
      m_q       <= '0;
      illegal_q <= 1'b0;
    end else begin
      m_q       <= '{valid: x_q.valid, rd: x_q.rd, wr: x_q.wr, cls: x_q.cls};
      x_q       <= x_d;
      illegal_q <= illegal_q | (d_ill & ~kill);
    end
  end

  always_comb begin
    mem_to_reg = WB_PC4;
    if (m_q.valid) begin
      case (m_q.cls)
        CLS_JAL, CLS_JALR: mem_to_reg = WB_PC4;
        CLS_LOAD:          mem_to_reg = (bus.addr_M_hi == UART_REGION) ? WB_UART : WB_DMEM;
        default:           mem_to_reg = WB_ALU;
      endcase
    end
  end

  assign bus.PC_sel       = pc_sel;
  assign bus.fwd_sel_a    = fwd_a;
  assign bus.fwd_sel_b    = fwd_b;
  assign bus.stall        = stall;
  assign bus.flush        = flush;
  assign bus.dmem_we      = x_q.valid && x_q.is_store;
  assign bus.RegWr        = m_q.valid && m_q.wr;
  assign bus.MemToReg     = mem_to_reg;
  assign bus.illegal_inst = illegal_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: reset sequencing, then a table of
// per-cycle instructions with hand-computed outputs, then mid-stall reset.
module tb_pipeline_control;
  import pipeline_ctrl_pkg::*;

  localparam int OW = 13;

  logic Clock;
  logic Reset_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [OW-1:0] exp_q[$];

  pipeline_control_if bus ();

  pipeline_control #(.RESET_CYCLES(2)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus.master)
  );

  // clock / watchdog
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // instruction encoders
  function automatic logic [31:0] enc_add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_lw(logic [4:0] rd, logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_sw(logic [4:0] rs2, logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_beq(logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_jal(logic [4:0] rd);
    return {20'd0, rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_jalr(logic [4:0] rd, logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ILL = 32'h0000_007F;

  typedef struct {
    logic [31:0] inst;
    logic        bt;
    logic [3:0]  hi;
    logic [1:0]  pc, fa, fb;
    logic        st, fl, we, rw;
    logic [1:0]  mtr;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(logic [31:0] inst, logic bt, logic [3:0] hi,
                         logic [1:0] pc, logic [1:0] fa, logic [1:0] fb,
                         logic st, logic fl, logic we, logic rw,
                         logic [1:0] mtr, logic ill);
    vec_t v;
    v.inst = inst; v.bt = bt; v.hi = hi;
    v.pc = pc; v.fa = fa; v.fb = fb; v.st = st; v.fl = fl;
    v.we = we; v.rw = rw; v.mtr = mtr; v.ill = ill;
    vecs.push_back(v);
  endtask

  // driver tasks
  task automatic drive(logic [31:0] inst, logic bt, logic [3:0] hi);
    bus.inst         = inst;
    bus.branch_taken = bt;
    bus.addr_M_hi    = hi;
  endtask

  task automatic expect_out(logic [1:0] pc, logic [1:0] fa, logic [1:0] fb,
                            logic st, logic fl, logic we, logic rw,
                            logic [1:0] mtr, logic ill);
    exp_q.push_back({pc, fa, fb, st, fl, we, rw, mtr, ill});
  endtask

  // scoreboard
  task automatic cmp(string tag, string field, int act, int want);
    n_cmp++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d want %0d", tag, field, act, want);
    end
  endtask

  task automatic score(string tag);
    logic [OW-1:0] e;
    logic [OW-1:0] a;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.queue: got empty want entry", tag);
      return;
    end
    e = exp_q.pop_front();
    a = {bus.PC_sel, bus.fwd_sel_a, bus.fwd_sel_b, bus.stall, bus.flush,
         bus.dmem_we, bus.RegWr, bus.MemToReg, bus.illegal_inst};
    cmp(tag, "PC_sel",       int'(a[12:11]), int'(e[12:11]));
    cmp(tag, "fwd_sel_a",    int'(a[10:9]),  int'(e[10:9]));
    cmp(tag, "fwd_sel_b",    int'(a[8:7]),   int'(e[8:7]));
    cmp(tag, "stall",        int'(a[6]),     int'(e[6]));
    cmp(tag, "flush",        int'(a[5]),     int'(e[5]));
    cmp(tag, "dmem_we",      int'(a[4]),     int'(e[4]));
    cmp(tag, "RegWr",        int'(a[3]),     int'(e[3]));
    cmp(tag, "MemToReg",     int'(a[2:1]),   int'(e[2:1]));
    cmp(tag, "illegal_inst", int'(a[0]),     int'(e[0]));
  endtask

  initial begin
    //      inst                bt  hi    pc fa fb st fl we rw mtr ill
    add_vec(enc_add(5, 1, 2),   0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(enc_add(6, 5, 3),   0, 4'h0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    add_vec(enc_add(5, 1, 2),   0, 4'h0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    add_vec(NOP,                0, 4'h0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    add_vec(enc_add(6, 5, 3),   0, 4'h0, 1, 2, 0, 0, 0, 0, 1, 1, 0);
    add_vec(enc_add(0, 1, 2),   0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec(enc_add(6, 0, 3),   0, 4'h0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    add_vec(enc_lw(5, 1),       0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec(enc_add(6, 2, 5),   0, 4'h1, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    add_vec(enc_add(6, 2, 5),   0, 4'h1, 1, 0, 2, 0, 0, 0, 1, 2, 0);
    add_vec(enc_sw(5, 6),       0, 4'h0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add_vec(NOP,                0, 4'h0, 1, 0, 0, 0, 0, 1, 1, 1, 0);
    add_vec(enc_beq(1, 2),      1, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec(enc_addi(7, 0, 1),  1, 4'h0, 2, 0, 0, 0, 1, 0, 0, 1, 0);
    add_vec(enc_addi(8, 0, 2),  0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec(NOP,                0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(enc_jal(1),         0, 4'h0, 2, 0, 0, 0, 0, 0, 1, 1, 0);
    add_vec(enc_lw(9, 10),      0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec(NOP,                0, 4'h8, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add_vec(NOP,                0, 4'h8, 1, 0, 0, 0, 0, 0, 1, 3, 0);
    add_vec(enc_jalr(0, 1),     0, 4'h0, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec(NOP,                0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec(NOP,                0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(ILL,                0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec(NOP,                0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add_vec(NOP,                0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 1);

    // reset held for three cycles, then two sequencing cycles
    Reset_n = 1'b0;
    drive(NOP, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock); #1;
      expect_out(3, 0, 0, 0, 1, 0, 0, 0, 0);
      score($sformatf("reset_low%0d", i));
    end
    Reset_n = 1'b1;
    #1;
    expect_out(3, 0, 0, 0, 1, 0, 0, 0, 0);
    score("reset_seq0");
    @(negedge Clock); #1;
    expect_out(3, 0, 0, 0, 1, 0, 0, 0, 0);
    score("reset_seq1");
    @(negedge Clock); #1;
    expect_out(1, 0, 0, 0, 0, 0, 0, 0, 0);
    score("reset_done");

    // table of per-cycle vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clock);
      drive(vecs[i].inst, vecs[i].bt, vecs[i].hi);
      #1;
      expect_out(vecs[i].pc, vecs[i].fa, vecs[i].fb, vecs[i].st, vecs[i].fl,
                 vecs[i].we, vecs[i].rw, vecs[i].mtr, vecs[i].ill);
      score($sformatf("row%0d", i));
    end

    // reset pulsed during a load-use stall
    @(negedge Clock);
    drive(enc_lw(5, 1), 1'b0, 4'h0);
    #1;
    expect_out(1, 0, 0, 0, 0, 0, 0, 1, 1);
    score("mid_lw");
    @(negedge Clock);
    drive(enc_add(6, 2, 5), 1'b0, 4'h0);
    #1;
    expect_out(0, 0, 0, 1, 0, 0, 0, 1, 1);
    score("mid_stall");
    #1;
    Reset_n = 1'b0;
    #1;
    expect_out(3, 0, 0, 0, 1, 0, 0, 0, 0);
    score("mid_reset");
    @(negedge Clock);
    Reset_n = 1'b1;
    #1;
    expect_out(3, 0, 0, 0, 1, 0, 0, 0, 0);
    score("mid_seq0");
    @(negedge Clock); #1;
    expect_out(3, 0, 0, 0, 1, 0, 0, 0, 0);
    score("mid_seq1");
    @(negedge Clock); #1;
    expect_out(1, 0, 0, 0, 0, 0, 0, 0, 0);
    score("mid_resume");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
